// File: rtl/cs_key_pkg.sv
// cs_key_pkg: shared widths, vector types and FSM states for the CS-cipher round-key sequencer.
package cs_key_pkg;
  localparam int KEY_W = 64;
  localparam int NUM_KEYS = 9;
  localparam int IDX_W = 4;
  typedef logic [KEY_W-1:0] subkey_t;
  typedef logic [KEY_W*NUM_KEYS-1:0] rk_vec_t;
  typedef enum logic [1:0] {EMPTY, LOADED, STREAM} rks_state_t;
endpackage

// File: rtl/cs_rk_mux.sv
// cs_rk_mux: combinational subkey selector.
//   keys   - packed key set, subkey i at keys[i*KEY_W +: KEY_W]
//   idx    - subkey index (0..NUM_KEYS-1)
//   subkey - selected subkey
module cs_rk_mux
  import cs_key_pkg::*;
(
  input  logic [KEY_W*NUM_KEYS-1:0] keys,
  input  logic [IDX_W-1:0]          idx,
  output logic [KEY_W-1:0]          subkey
);
  assign subkey = keys[idx*KEY_W +: KEY_W];
endmodule

// File: rtl/cs_round_key_seq.sv
// cs_round_key_seq: captures a 9-subkey set from the key schedule and streams it per round.
//   keys_ready/round_keys   - key-schedule done level and key vector (captured on 0->1)
//   key_invalidate          - discards active and pending keys, aborts a running pass
//   pass_start/dir          - start a pass; dir 0 = k0..k8, 1 = k8..k0
//   subkey_out/idx/valid    - streamed subkey, handshaked with subkey_ready
//   pass_done/pass_abort/err_no_key - single-cycle status pulses
//   keys_loaded/busy        - key set held / pass in progress
// Optional: CS_KEY_ZEROIZE_EN zeroes subkey_out while invalid and clears buffers on invalidate.
module cs_round_key_seq
  import cs_key_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      keys_ready,
  input  logic [KEY_W*NUM_KEYS-1:0] round_keys,
  input  logic                      key_invalidate,
  input  logic                      pass_start,
  input  logic                      dir,
  output logic [KEY_W-1:0]          subkey_out,
  output logic [IDX_W-1:0]          subkey_idx,
  output logic                      subkey_valid,
  input  logic                      subkey_ready,
  output logic                      pass_done,
  output logic                      pass_abort,
  output logic                      err_no_key,
  output logic                      keys_loaded,
  output logic                      busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);
  rks_state_t state;
  rk_vec_t active, pending;
  logic pending_vld, kr_q, dir_q;
  logic [IDX_W-1:0] idx;
  subkey_t sel;
  wire capture = keys_ready && !kr_q;
  // terminal index depends on direction, so idx never steps outside 0..NUM_KEYS-1
  wire last = dir_q ? (idx == '0) : (idx == LAST);

  cs_rk_mux u_mux (.keys(active), .idx(idx), .subkey(sel));

  assign busy = state == STREAM;
  assign subkey_valid = busy;
  assign keys_loaded = state != EMPTY;
  assign subkey_idx = idx;
`ifdef CS_KEY_ZEROIZE_EN
  assign subkey_out = subkey_valid ? sel : '0;
`else
  assign subkey_out = sel;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      active <= '0;
      pending <= '0;
      pending_vld <= 1'b0;
      kr_q <= 1'b0;
      idx <= '0;
      dir_q <= 1'b0;
      pass_done <= 1'b0;
      pass_abort <= 1'b0;
      err_no_key <= 1'b0;
    end else begin
      kr_q <= keys_ready;
      pass_done <= 1'b0;
      pass_abort <= 1'b0;
      err_no_key <= 1'b0;
      if (key_invalidate) begin
        state <= EMPTY;
        pending_vld <= 1'b0;
        pass_abort <= state == STREAM;
`ifdef CS_KEY_ZEROIZE_EN
        active <= '0;
        pending <= '0;
`endif
      end else begin
        case (state)
          EMPTY: begin
            if (capture) begin
              active <= round_keys;
              state <= LOADED;
            end
            err_no_key <= pass_start;
          end
          LOADED: begin
            if (capture) active <= round_keys;
            if (pass_start) begin
              dir_q <= dir;
              idx <= dir ? LAST : '0;
              state <= STREAM;
            end
          end
          STREAM: begin
            if (capture) begin
              pending <= round_keys;
              pending_vld <= 1'b1;
            end
            if (subkey_ready) begin
              if (last) begin
                pass_done <= 1'b1;
                state <= LOADED;
                pending_vld <= 1'b0;
                // a capture on the final transfer is newer than anything already pending
                if (capture) active <= round_keys;
                else if (pending_vld) active <= pending;
              end else begin
                idx <= dir_q ? idx - 1'b1 : idx + 1'b1;
              end
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
endmodule

// File: tb/tb_cs_round_key_seq.sv
// tb_cs_round_key_seq: directed plus randomized self-checking bench for cs_round_key_seq.
module tb_cs_round_key_seq;
  import cs_key_pkg::*;
  logic clk = 0, rst_n = 0, keys_ready = 0, key_invalidate = 0, pass_start = 0, dir = 0, subkey_ready = 0;
  logic [KEY_W*NUM_KEYS-1:0] round_keys = '0;
  logic [KEY_W-1:0] subkey_out;
  logic [IDX_W-1:0] subkey_idx;
  logic subkey_valid, pass_done, pass_abort, err_no_key, keys_loaded, busy;
  int n_cmp = 0, n_err = 0;
  subkey_t m_act[NUM_KEYS], m_pend[NUM_KEYS], nk[NUM_KEYS];
  bit m_pv = 0;

  always #5 clk = ~clk;

  cs_round_key_seq dut (
    .clk(clk), .rst_n(rst_n), .keys_ready(keys_ready), .round_keys(round_keys),
    .key_invalidate(key_invalidate), .pass_start(pass_start), .dir(dir),
    .subkey_out(subkey_out), .subkey_idx(subkey_idx), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .pass_done(pass_done), .pass_abort(pass_abort),
    .err_no_key(err_no_key), .keys_loaded(keys_loaded), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [KEY_W*NUM_KEYS-1:0] pack_nk();
    logic [KEY_W*NUM_KEYS-1:0] v;
    for (int i = 0; i < NUM_KEYS; i++) v[i*KEY_W +: KEY_W] = nk[i];
    return v;
  endfunction

  task automatic load_keys();
    round_keys = pack_nk();
    keys_ready = 1;
    @(negedge clk);
    keys_ready = 0;
    round_keys = {NUM_KEYS{64'hDEAD_BEEF_0BAD_F00D}};
    m_act = nk;
    chk("keys_loaded", keys_loaded, 1);
    chk("busy_idle", busy, 0);
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready
  task automatic do_pass(input bit d, input int mode, input int cap_at, input int inv_at);
    int t = 0, c = 0, k;
    bit r, inv = 0, cap = 0;
    pass_start = 1;
    dir = d;
    @(negedge clk);
    pass_start = 0;
    dir = 1'($urandom_range(0, 1));
    while (1) begin
      if (c > 200) begin
        chk("pass_timeout", c, 200);
        return;
      end
      k = d ? NUM_KEYS - 1 - t : t;
      chk("valid", subkey_valid, 1);
      chk("busy", busy, 1);
      chk("idx", subkey_idx, k);
      chk("subkey", subkey_out, m_act[k]);
      chk("done_low", pass_done, 0);
      r = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      subkey_ready = r;
      if (mode == 2) pass_start = 1'($urandom_range(0, 1));
      if (r && t == cap_at) begin
        round_keys = pack_nk();
        keys_ready = 1;
        cap = 1;
      end
      if (r && t == inv_at) begin
        key_invalidate = 1;
        inv = 1;
      end
      @(negedge clk);
      c++;
      keys_ready = 0;
      key_invalidate = 0;
      pass_start = 0;
      subkey_ready = 0;
      if (cap) begin
        m_pend = nk;
        m_pv = 1;
        cap = 0;
      end
      if (inv) begin
        chk("abort_pulse", pass_abort, 1);
        chk("abort_no_done", pass_done, 0);
        chk("abort_valid", subkey_valid, 0);
        chk("abort_loaded", keys_loaded, 0);
        chk("abort_busy", busy, 0);
`ifdef CS_KEY_ZEROIZE_EN
        chk("abort_zero", subkey_out, 0);
`endif
        m_pv = 0;
        return;
      end
      if (r) t++;
      if (t == NUM_KEYS) begin
        chk("done_pulse", pass_done, 1);
        chk("done_valid", subkey_valid, 0);
        chk("done_loaded", keys_loaded, 1);
        chk("done_no_abort", pass_abort, 0);
        if (m_pv) begin
          m_act = m_pend;
          m_pv = 0;
        end
        return;
      end
    end
  endtask

  initial begin
    #1;
    chk("rst_valid", subkey_valid, 0);
    chk("rst_subkey", subkey_out, 0);
    chk("rst_loaded", keys_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_no_key, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // pass request with no key set
    pass_start = 1;
    @(negedge clk);
    pass_start = 0;
    chk("err_no_key", err_no_key, 1);
    chk("nokey_valid", subkey_valid, 0);
    @(negedge clk);
    chk("err_one_cycle", err_no_key, 0);
    chk("nokey_empty", keys_loaded, 0);
    // encrypt, full throughput
    for (int i = 0; i < NUM_KEYS; i++) nk[i] = 64'h1111111111111111 * (i + 1);
    load_keys();
    do_pass(0, 0, -1, -1);
    @(negedge clk);
    chk("done_single", pass_done, 0);
    // decrypt with backpressure
    do_pass(1, 1, -1, -1);
    @(negedge clk);
    // new set captured mid-pass goes to pending, then becomes active
    for (int i = 0; i < NUM_KEYS; i++) nk[i] = 64'hA5A5A5A5A5A5A5A5;
    do_pass(0, 0, 4, -1);
    @(negedge clk);
    do_pass(1, 0, -1, -1);
    @(negedge clk);
    // randomized passes with random key sets, direction, ready and captures
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NUM_KEYS; i++) nk[i] = {$urandom, $urandom};
      if (n % 2 == 0) load_keys();
      else for (int i = 0; i < NUM_KEYS; i++) nk[i] = {$urandom, $urandom};
      do_pass(1'($urandom_range(0, 1)), 2, (n % 2 == 1) ? int'($urandom_range(0, NUM_KEYS - 1)) : -1, -1);
      @(negedge clk);
    end
    // abort at transfer 3
    do_pass(0, 0, -1, 3);
    @(negedge clk);
    chk("abort_single", pass_abort, 0);
    pass_start = 1;
    @(negedge clk);
    pass_start = 0;
    chk("post_abort_err", err_no_key, 1);
    // asynchronous reset in the middle of a pass
    for (int i = 0; i < NUM_KEYS; i++) nk[i] = {$urandom, $urandom};
    load_keys();
    pass_start = 1;
    dir = 0;
    @(negedge clk);
    pass_start = 0;
    subkey_ready = 1;
    repeat (3) @(negedge clk);
    subkey_ready = 0;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", subkey_valid, 0);
    chk("arst_subkey", subkey_out, 0);
    chk("arst_idx", subkey_idx, 0);
    chk("arst_loaded", keys_loaded, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("arst_no_done", pass_done, 0);
    chk("arst_no_abort", pass_abort, 0);
    chk("arst_empty", keys_loaded, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cs_round_key_seq.md
Name: cs_round_key_seq

Overview:
- Sits directly downstream of the CS-cipher key schedule.
- Captures the 576-bit round-key vector (9 x 64-bit subkeys) when the key schedule signals completion.
- Streams one subkey per round to the cipher datapath over a valid/ready handshake.
- Encrypt order is k0..k8; decrypt order is k8..k0. A shadow buffer lets a new key set arrive while a pass is in flight.

Parameters:
- KEY_W, 64, subkey width in bits.
- NUM_KEYS, 9, subkeys per key set; round_keys width = KEY_W*NUM_KEYS.
- IDX_W, 4, subkey index width; must satisfy 2**IDX_W >= NUM_KEYS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- keys_ready  in  1  key-schedule done level; a capture occurs on its 0->1 transition.
- round_keys  in  KEY_W*NUM_KEYS  subkey i = round_keys[i*KEY_W +: KEY_W].
- key_invalidate  in  1  pulse; discards active and pending keys; tied to key-schedule start.
- pass_start  in  1  pulse; requests one full subkey pass.
- dir  in  1  sampled with pass_start; 0 = encrypt (ascending), 1 = decrypt (descending).
- subkey_out  out  KEY_W  current subkey.
- subkey_idx  out  IDX_W  index of subkey_out within the set.
- subkey_valid  out  1  subkey_out/subkey_idx valid.
- subkey_ready  in  1  consumer accepts the current subkey.
- pass_done  out  1  one-cycle pulse after the final transfer of a pass.
- pass_abort  out  1  one-cycle pulse when a pass is killed by key_invalidate.
- err_no_key  out  1  one-cycle pulse when pass_start arrives in EMPTY.
- keys_loaded  out  1  an active key set is held.
- busy  out  1  state == STREAM.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state EMPTY.
  - Active and pending buffers cleared; pending_vld=0.
  - Edge-detect register for keys_ready = 0.
- Capture event: keys_ready==1 while its registered copy ==0. round_keys is sampled in that same cycle.
- States:
  - EMPTY:
    - capture -> active <= round_keys, go to LOADED.
    - pass_start -> err_no_key pulses next cycle; stay in EMPTY.
  - LOADED:
    - pass_start -> latch dir; idx <= 0 (dir=0) or NUM_KEYS-1 (dir=1); go to STREAM.
    - subkey_valid=1 from the next cycle. Latency pass_start -> first valid = 1 cycle.
    - capture in LOADED overwrites active directly.
  - STREAM:
    - subkey_out = active[idx]; subkey_valid=1.
    - Outputs stay stable while subkey_ready=0.
    - On valid&&ready: idx steps +1 (dir=0) or -1 (dir=1).
    - After the last transfer (idx 8 for dir=0, idx 0 for dir=1): subkey_valid=0 next cycle, pass_done=1 for one cycle, go to LOADED.
    - Full-throughput pass, with ready held high, is exactly NUM_KEYS transfer cycles.
    - pass_start in STREAM is ignored, with no error.
    - capture in STREAM: round_keys goes to the pending buffer, pending_vld=1. A second capture overwrites pending.
    - At pass end: if pending_vld, active <= pending and pending_vld=0, in the same cycle as the transition to LOADED.
- key_invalidate (any state, highest priority over capture and pass_start in the same cycle):
  - Next cycle: state EMPTY, keys_loaded=0, pending_vld=0, subkey_valid=0.
  - If the state was STREAM, pass_abort pulses and pass_done does not.
- Idx arithmetic: no wrap. idx never leaves 0..NUM_KEYS-1; the terminal compare prevents underflow and overflow.
- keys_loaded=1 in LOADED and STREAM.
- Handshake: valid never drops without a transfer, except on invalidate or reset.
- Reset mid-pass: immediate clear; no pass_done or pass_abort.

Optional Feature:
- Macro: CS_KEY_ZEROIZE_EN.
- When defined:
  - subkey_out is forced to 0 whenever subkey_valid=0.
  - On key_invalidate, the active and pending buffers are cleared to 0.
- When undefined:
  - subkey_out holds active[idx] at all times.
  - Invalidate only clears the valid flags; buffer contents are retained.

Decomposition:
- Package cs_key_pkg holds:
  - KEY_W, NUM_KEYS, IDX_W.
  - subkey_t (logic [KEY_W-1:0]).
  - rk_vec_t (logic [KEY_W*NUM_KEYS-1:0]).
  - Enum rks_state_t {EMPTY, LOADED, STREAM}.
- One natural sub-module: cs_rk_mux, the combinational subkey selector (active vector + idx -> subkey_t). The FSM and buffers stay in the top module.

Test Plan:
- Encrypt pass: load keys with subkey i = 64'h1111111111111111*(i+1); pass_start with dir=0; ready held high.
  -> idx 0..8, subkey_out 64'h1111...1111 through 64'h9999...9999 on 9 consecutive cycles.
  -> pass_done one cycle after the idx-8 transfer.
- Decrypt pass with backpressure: same keys, dir=1; ready toggles 1,0,0,1...
  -> order is 64'h9999...9999 down to 64'h1111...1111.
  -> outputs stay stable during every ready=0 cycle.
  -> exactly 9 transfers, then pass_done.
- No key: pass_start after reset with no capture -> err_no_key=1 for one cycle; subkey_valid stays 0.
- Pending buffer: capture of a new set (all subkeys 64'hA5A5A5A5A5A5A5A5) at transfer 4 of a pass.
  -> the current pass completes with the old keys.
  -> the next pass outputs 64'hA5A5... for all 9 subkeys.
- Abort: key_invalidate at transfer 3.
  -> pass_abort pulses; subkey_valid=0 next cycle; keys_loaded=0; no pass_done.
  -> with CS_KEY_ZEROIZE_EN defined, subkey_out=0.
- Async reset mid-STREAM (rst_n low between clock edges) -> all outputs 0 immediately; state EMPTY after release.
